// File: rtl/mult_datapath.sv
// mult_datapath: X/A/B register datapath of the signed shift-add multiplier.
// It executes one command strobe per clock edge from the control unit and
// returns the current multiplier LSB (M) to that unit.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr_Ld,
  input  logic             Clr_XA,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Shift,
  input  logic [WIDTH-1:0] S,
  output logic             X,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             M
);

  logic [WIDTH:0] op_a;
  logic [WIDTH:0] op_b;
  logic [WIDTH:0] sum9;
  logic [WIDTH:0] carry;

  // Shared WIDTH+1-bit ripple adder; Sub selects the inverted operand and carry-in 1.
  always_comb begin
    op_a     = {Aval[WIDTH-1], Aval};
    op_b     = Sub ? ~{S[WIDTH-1], S} : {S[WIDTH-1], S};
    carry    = '0;
    sum9     = '0;
    carry[0] = Sub;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      sum9[i] = op_a[i] ^ op_b[i] ^ carry[i];
    end
  end

  // State update: only the highest-priority asserted strobe takes effect.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      X    <= 1'b0;
      Aval <= '0;
      Bval <= '0;
    end else if (Clr_Ld) begin
      X    <= 1'b0;
      Aval <= '0;
      Bval <= S;
    end else if (Clr_XA) begin
      X    <= 1'b0;
      Aval <= '0;
    end else if (Sub || Add) begin
      // Sub outranks Add; the adder already follows Sub, so one branch serves both.
      if (M) begin
        X    <= sum9[WIDTH];
        Aval <= sum9[WIDTH-1:0];
      end
    end else if (Shift) begin
      Aval <= {X, Aval[WIDTH-1:1]};
      Bval <= {Aval[0], Bval[WIDTH-1:1]};
    end
  end

  // Multiplier LSB feeds the control unit with no extra latency.
  always_comb begin
    M = Bval[0];
  end

endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed and randomized checks of mult_datapath against
// an arithmetic reference model of X, A and B.
module tb_mult_datapath;

  logic       Clk;
  logic       Reset;
  logic       Clr_Ld, Clr_XA, Add, Sub, Shift;
  logic [7:0] S;
  logic       X, M;
  logic [7:0] Aval, Bval;

  int checks = 0;
  int errors = 0;

  // reference state
  logic       mx;
  logic [7:0] ma, mb;

  mult_datapath #(.WIDTH(8)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clr_Ld (Clr_Ld),
    .Clr_XA (Clr_XA),
    .Add    (Add),
    .Sub    (Sub),
    .Shift  (Shift),
    .S      (S),
    .X      (X),
    .Aval   (Aval),
    .Bval   (Bval),
    .M      (M)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ":X"}, 32'(X),    32'(mx));
    check({tag, ":A"}, 32'(Aval), 32'(ma));
    check({tag, ":B"}, 32'(Bval), 32'(mb));
    check({tag, ":M"}, 32'(M),    32'(mb[0]));
  endtask

  // Reference: signed arithmetic on integers, shift on the signed 17-bit {X,A,B}.
  task automatic model_step(input logic cl, cx, ad, sb, sh, input logic [7:0] s);
    int a_i, s_i, r;
    logic signed [16:0] cat;
    a_i = int'($signed(ma));
    s_i = int'($signed(s));
    if (cl) begin
      mb = s; ma = 8'h00; mx = 1'b0;
    end else if (cx) begin
      ma = 8'h00; mx = 1'b0;
    end else if (sb) begin
      if (mb[0]) begin r = a_i - s_i; ma = r[7:0]; mx = r[8]; end
    end else if (ad) begin
      if (mb[0]) begin r = a_i + s_i; ma = r[7:0]; mx = r[8]; end
    end else if (sh) begin
      cat = {mx, ma, mb};
      cat = cat >>> 1;
      {mx, ma, mb} = cat;
    end
  endtask

  // One clock with the given strobes, then compare against the model.
  task automatic strobe(input logic cl, cx, ad, sb, sh, input logic [7:0] s, input string tag);
    Clr_Ld = cl; Clr_XA = cx; Add = ad; Sub = sb; Shift = sh; S = s;
    @(posedge Clk);
    model_step(cl, cx, ad, sb, sh, s);
    #1;
    Clr_Ld = 0; Clr_XA = 0; Add = 0; Sub = 0; Shift = 0;
    check_state(tag);
  endtask

  task automatic run_seq(input logic [7:0] s, input string tag);
    for (int i = 0; i < 7; i++) begin
      strobe(0, 0, 1, 0, 0, s, {tag, ":add"});
      strobe(0, 0, 0, 0, 1, s, {tag, ":shf"});
    end
    strobe(0, 0, 0, 1, 0, s, {tag, ":sub"});
    strobe(0, 0, 0, 0, 1, s, {tag, ":shf"});
  endtask

  task automatic check_product(input logic [7:0] b, input logic [7:0] s, input string tag);
    int p;
    p = int'($signed(b)) * int'($signed(s));
    check({tag, ":prod"}, 32'({Aval, Bval}), 32'(p[15:0]));
    check({tag, ":xsign"}, 32'(X), 32'(p[15]));
  endtask

  task automatic multiply(input logic [7:0] b, input logic [7:0] s, input string tag);
    strobe(1, 0, 0, 0, 0, b, {tag, ":ld"});
    run_seq(s, tag);
    check_product(b, s, tag);
  endtask

  initial begin
    Reset = 0; Clr_Ld = 0; Clr_XA = 0; Add = 0; Sub = 0; Shift = 0; S = 8'h00;
    mx = 0; ma = 8'h00; mb = 8'h00;

    // reset held with random strobes
    #1;
    check_state("rst0");
    for (int i = 0; i < 8; i++) begin
      {Clr_Ld, Clr_XA, Add, Sub, Shift} = 5'($urandom);
      S = 8'($urandom);
      @(posedge Clk); #1;
      check_state("rst");
    end
    {Clr_Ld, Clr_XA, Add, Sub, Shift} = 5'b0;
    #2 Reset = 1;
    #1;

    // load then shift
    strobe(1, 0, 0, 0, 0, 8'h07, "load");
    check("load:B07", 32'(Bval), 32'h07);
    check("load:M1", 32'(M), 32'h1);
    strobe(0, 0, 0, 0, 1, 8'h07, "ldshf");
    check("ldshf:B03", 32'(Bval), 32'h03);

    // directed multiplies
    multiply(8'h07, 8'h3B, "pos");
    check("pos:A", 32'(Aval), 32'h01);
    check("pos:B", 32'(Bval), 32'h9D);
    multiply(8'hFE, 8'h03, "neg");
    check("neg:A", 32'(Aval), 32'hFF);
    check("neg:B", 32'(Bval), 32'hFA);
    check("neg:X", 32'(X), 32'h1);
    multiply(8'h80, 8'h80, "corner");
    check("corner:A", 32'(Aval), 32'h40);
    check("corner:B", 32'(Bval), 32'h00);

    // Add/Sub with M = 0 hold everything; set up A nonzero first
    strobe(1, 0, 0, 0, 0, 8'h03, "m0:ld");
    strobe(0, 0, 1, 0, 0, 8'h25, "m0:add1");
    strobe(0, 0, 0, 0, 1, 8'h25, "m0:shf");
    strobe(0, 0, 0, 0, 1, 8'h25, "m0:shf2");
    strobe(0, 0, 1, 0, 0, 8'h11, "m0:addhold");
    strobe(0, 0, 0, 1, 1, 8'h11, "m0:subhold");

    // priority
    strobe(1, 0, 0, 0, 1, 8'h55, "pri:ldshf");
    check("pri:B55", 32'(Bval), 32'h55);
    strobe(0, 0, 1, 0, 0, 8'h7F, "pri:seta");
    strobe(0, 1, 1, 0, 0, 8'h7F, "pri:xaadd");
    check("pri:A0", 32'(Aval), 32'h00);
    strobe(0, 0, 1, 1, 0, 8'h10, "pri:subadd");
    strobe(0, 0, 1, 0, 1, 8'h10, "pri:addshf");

    // held strobes repeat
    Shift = 1;
    repeat (3) begin
      @(posedge Clk); model_step(0, 0, 0, 0, 1, S); #1;
      check_state("hold:shf");
    end
    Shift = 0;

    // reset during the 5th strobe of a multiply
    strobe(1, 0, 0, 0, 0, 8'h6B, "mid:ld");
    strobe(0, 0, 1, 0, 0, 8'h2D, "mid:1");
    strobe(0, 0, 0, 0, 1, 8'h2D, "mid:2");
    strobe(0, 0, 1, 0, 0, 8'h2D, "mid:3");
    strobe(0, 0, 0, 0, 1, 8'h2D, "mid:4");
    Add = 1; S = 8'h2D;
    #2 Reset = 0;
    mx = 0; ma = 8'h00; mb = 8'h00;
    #1;
    check_state("mid:rstnow");
    @(posedge Clk); #1;
    check_state("mid:rstedge");
    Add = 0;
    #2 Reset = 1;
    #1;

    // consecutive multiply using Clr_XA on a dirty accumulator
    strobe(1, 0, 0, 0, 0, 8'h0D, "cons:ld");
    strobe(0, 0, 1, 0, 0, 8'h44, "cons:dirty");
    strobe(0, 1, 0, 0, 0, 8'h2D, "cons:clrxa");
    run_seq(8'h2D, "cons");
    check_product(8'h0D, 8'h2D, "cons");

    // random multiplies
    for (int n = 0; n < 30; n++) begin
      logic [7:0] rb, rs;
      rb = 8'($urandom);
      rs = 8'($urandom);
      if (n % 2 == 0) begin
        multiply(rb, rs, "rmul");
      end else begin
        strobe(1, 0, 0, 0, 0, rb, "rmul:ld");
        strobe(0, 0, 1, 0, 0, 8'($urandom), "rmul:dirty");
        strobe(0, 1, 0, 0, 0, rs, "rmul:clrxa");
        run_seq(rs, "rmul");
        check_product(rb, rs, "rmul");
      end
    end

    // random strobe stream, any combination of strobes
    for (int n = 0; n < 150; n++) begin
      logic [4:0] st;
      st = 5'($urandom) & 5'($urandom);
      strobe(st[4], st[3], st[2], st[1], st[0], 8'($urandom), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
